// File: rtl/msoc_rstseq_pkg.sv
// Shared state encoding, parameter defaults and small helpers for the
// msoc_reset_seq reset sequencer.
package msoc_rstseq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_BREAK   = 3'd3,
        ST_HALT    = 3'd4
    } seq_state_t;

    localparam int NCH_DEF         = 4;
    localparam int HOLD_CYC_DEF    = 10;
    localparam int STAGGER_DEF     = 2;
    localparam int BRK_FILT_DEF    = 3;
    localparam int MAX_RESTART_DEF = 3;
    localparam int WDT_W_DEF       = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/msoc_brk_filter.sv
// Consecutive-high filter: hit asserts on the BRK_FILT-th consecutive high
// sample of din; any low sample or clr restarts the count.
module msoc_brk_filter
    import msoc_rstseq_pkg::*;
#(
    parameter int BRK_FILT = BRK_FILT_DEF
) (
    input  logic msoc_clk,
    input  logic rstn,
    input  logic clr,
    input  logic din,
    output logic hit
);

    localparam int CW = $clog2(BRK_FILT + 1);
    localparam logic [CW-1:0] LAST = CW'(BRK_FILT - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge msoc_clk) begin
        if (!rstn || clr || !din) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign hit = din && (cnt_reg == LAST);

endmodule

// File: rtl/msoc_reset_seq.sv
// Staggered multi-channel reset sequencer with break/restart budget.
// Optional watchdog enabled by defining MSOC_RSTSEQ_WDT_EN.
module msoc_reset_seq
    import msoc_rstseq_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int HOLD_CYC    = HOLD_CYC_DEF,
    parameter int STAGGER     = STAGGER_DEF,
    parameter int BRK_FILT    = BRK_FILT_DEF,
    parameter int MAX_RESTART = MAX_RESTART_DEF,
    parameter int WDT_W       = WDT_W_DEF
) (
    input  logic             msoc_clk,
    input  logic             rstn,
    input  logic             u_break,
    input  logic             sw_rst_req,
    input  logic             wdt_kick,
    input  logic [WDT_W-1:0] wdt_limit,
    output logic [NCH-1:0]   rst_out_n,
    output logic             done,
    output logic             halt,
    output logic             wdt_fired,
    output logic [7:0]       restart_cnt,
    output logic [2:0]       seq_state
);

    localparam int SEQ_END = HOLD_CYC + (NCH - 1) * STAGGER;
    localparam int CW      = $clog2(SEQ_END + 2);
    localparam logic [7:0] MAX_R = 8'(MAX_RESTART);

    seq_state_t     state_reg, state_next;
    logic [CW-1:0]  cyc_reg, cyc_next;
    logic [NCH-1:0] rst_n_reg, rst_n_next;
    logic [NCH-1:0] rel_hit;
    logic [7:0]     restart_reg, restart_next;
    logic           fired_reg, fired_next;
    logic           brk_hit, wdt_hit;

    msoc_brk_filter #(.BRK_FILT(BRK_FILT)) u_filter (
        .msoc_clk (msoc_clk),
        .rstn     (rstn),
        .clr      (state_reg != ST_RUN),
        .din      (u_break),
        .hit      (brk_hit)
    );

    // Channel gi is released on the edge where the sequence counter hits its slot.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rel
            assign rel_hit[gi] = (cyc_reg == CW'(HOLD_CYC + gi * STAGGER));
        end
    endgenerate

`ifdef MSOC_RSTSEQ_WDT_EN
    logic [WDT_W-1:0] wdt_cnt_reg;

    always_ff @(posedge msoc_clk) begin
        if (!rstn || state_reg != ST_RUN || wdt_kick) begin
            wdt_cnt_reg <= '0;
        end else begin
            wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
        end
    end

    // Fires on the RUN cycle whose increment would reach the limit.
    assign wdt_hit = (state_reg == ST_RUN) && !wdt_kick && (wdt_limit != '0) &&
                     (({1'b0, wdt_cnt_reg} + {{WDT_W{1'b0}}, 1'b1}) == {1'b0, wdt_limit});
    assign wdt_fired = fired_reg;
`else
    logic unused_wdt;
    assign wdt_hit    = 1'b0;
    assign wdt_fired  = 1'b0;
    assign unused_wdt = ^{wdt_kick, wdt_limit, fired_reg};
`endif

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        rst_n_next   = rst_n_reg;
        restart_next = restart_reg;
        fired_next   = fired_reg;
        case (state_reg)
            ST_HOLD: begin
                cyc_next   = cyc_reg + 1'b1;
                rst_n_next = '0;
                if (rel_hit[0]) begin
                    rst_n_next[0] = 1'b1;
                    state_next    = (NCH == 1) ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (sw_rst_req) begin
                    state_next = ST_HOLD;
                    cyc_next   = '0;
                    rst_n_next = '0;
                end else begin
                    cyc_next   = cyc_reg + 1'b1;
                    rst_n_next = rst_n_reg | rel_hit;
                    if (rel_hit[NCH-1]) state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Software request outranks a break or timeout on the same edge.
                if (sw_rst_req) begin
                    state_next = ST_HOLD;
                    cyc_next   = '0;
                    rst_n_next = '0;
                end else if (brk_hit || wdt_hit) begin
                    state_next   = ST_BREAK;
                    rst_n_next   = '0;
                    restart_next = sat_inc8(restart_reg);
                    fired_next   = fired_reg | wdt_hit;
                end
            end
            ST_BREAK: begin
                cyc_next   = '0;
                rst_n_next = '0;
                state_next = (restart_reg >= MAX_R) ? ST_HALT : ST_HOLD;
            end
            ST_HALT: begin
                rst_n_next = '0;
                if (sw_rst_req) begin
                    state_next   = ST_HOLD;
                    cyc_next     = '0;
                    restart_next = '0;
                end
            end
            default: begin
                state_next = ST_HOLD;
                cyc_next   = '0;
                rst_n_next = '0;
            end
        endcase
    end

    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            state_reg   <= ST_HOLD;
            cyc_reg     <= '0;
            rst_n_reg   <= '0;
            restart_reg <= '0;
            fired_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cyc_reg     <= cyc_next;
            rst_n_reg   <= rst_n_next;
            restart_reg <= restart_next;
            fired_reg   <= fired_next;
        end
    end

    assign rst_out_n   = rst_n_reg;
    assign done        = (state_reg == ST_RUN);
    assign halt        = (state_reg == ST_HALT);
    assign restart_cnt = restart_reg;
    assign seq_state   = state_reg;

endmodule

// File: tb/tb_msoc_reset_seq.sv
// Scoreboard bench for msoc_reset_seq: stimulus pushes model predictions,
// a monitor pops and compares one observation per clock.
module tb_msoc_reset_seq;
    import msoc_rstseq_pkg::*;

    localparam int NCH         = 4;
    localparam int HOLD_CYC    = 10;
    localparam int STAGGER     = 2;
    localparam int BRK_FILT    = 3;
    localparam int MAX_RESTART = 3;
    localparam int WDT_W       = 16;
    localparam int SEQ_END     = HOLD_CYC + (NCH - 1) * STAGGER;

    logic             msoc_clk = 1'b0;
    logic             rstn = 1'b0;
    logic             u_break = 1'b0;
    logic             sw_rst_req = 1'b0;
    logic             wdt_kick = 1'b0;
    logic [WDT_W-1:0] wdt_limit = '0;
    logic [NCH-1:0]   rst_out_n;
    logic             done, halt, wdt_fired;
    logic [7:0]       restart_cnt;
    logic [2:0]       seq_state;

    msoc_reset_seq #(
        .NCH(NCH), .HOLD_CYC(HOLD_CYC), .STAGGER(STAGGER),
        .BRK_FILT(BRK_FILT), .MAX_RESTART(MAX_RESTART), .WDT_W(WDT_W)
    ) dut (
        .msoc_clk    (msoc_clk),
        .rstn        (rstn),
        .u_break     (u_break),
        .sw_rst_req  (sw_rst_req),
        .wdt_kick    (wdt_kick),
        .wdt_limit   (wdt_limit),
        .rst_out_n   (rst_out_n),
        .done        (done),
        .halt        (halt),
        .wdt_fired   (wdt_fired),
        .restart_cnt (restart_cnt),
        .seq_state   (seq_state)
    );

    always #5 msoc_clk = ~msoc_clk;

    typedef struct packed {
        logic [NCH-1:0] rst;
        logic           done;
        logic           halt;
        logic           fired;
        logic [7:0]     rc;
        logic [2:0]     st;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Model: phase 0 = sequencing (edges counted since sequence start),
    // 1 = break cycle, 2 = halted.
    int m_phase = 0;
    int m_edges = 0;
    int m_brk   = 0;
    int m_wdt   = 0;
    int m_rc    = 0;
    bit m_fired = 1'b0;

    function automatic bit model_in_run();
        return (m_phase == 0) && (m_edges > SEQ_END);
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        for (int k = 0; k < NCH; k++)
            o.rst[k] = (m_phase == 0) && (m_edges > HOLD_CYC + k * STAGGER);
        o.done  = model_in_run();
        o.halt  = (m_phase == 2);
        o.fired = m_fired;
        o.rc    = 8'(m_rc);
        if (m_phase == 1)             o.st = ST_BREAK;
        else if (m_phase == 2)        o.st = ST_HALT;
        else if (m_edges <= HOLD_CYC) o.st = ST_HOLD;
        else if (m_edges > SEQ_END)   o.st = ST_RUN;
        else                          o.st = ST_RELEASE;
        return o;
    endfunction

    task automatic model_edge(input bit r, input bit b, input bit s, input bit k,
                              input logic [WDT_W-1:0] lim);
        bit whit;
        whit = 1'b0;
        if (!r) begin
            m_phase = 0; m_edges = 0; m_brk = 0; m_wdt = 0; m_rc = 0; m_fired = 1'b0;
        end else if (m_phase == 0) begin
            if (s && m_edges > HOLD_CYC) begin
                m_edges = 0; m_brk = 0; m_wdt = 0;
            end else if (model_in_run()) begin
                m_brk = b ? m_brk + 1 : 0;
                m_wdt = k ? 0 : m_wdt + 1;
`ifdef MSOC_RSTSEQ_WDT_EN
                whit = !k && (lim != 0) && (m_wdt == int'(lim));
`endif
                if (m_brk >= BRK_FILT || whit) begin
                    m_phase = 1;
                    m_rc    = (m_rc < 255) ? m_rc + 1 : 255;
                    if (whit) m_fired = 1'b1;
                    m_brk = 0; m_wdt = 0;
                end else begin
                    m_edges++;
                end
            end else begin
                m_edges++;
            end
        end else if (m_phase == 1) begin
            m_phase = (m_rc >= MAX_RESTART) ? 2 : 0;
            m_edges = 0;
        end else if (s) begin
            m_phase = 0; m_edges = 0; m_rc = 0;
        end
        if (lim == '0 && whit) m_fired = 1'b1;
    endtask

    task automatic step(input bit r, input bit b, input bit s, input bit k,
                        input logic [WDT_W-1:0] lim, input string tag);
        @(negedge msoc_clk);
        rstn = r; u_break = b; sw_rst_req = s; wdt_kick = k; wdt_limit = lim;
        model_edge(r, b, s, k, lim);
        exp_q.push_back(model_out());
        tag_q.push_back(tag);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 100 && !model_in_run(); i++) step(1, 0, 0, 0, '0, "wait_run");
    endtask

    // Monitor: one observation per clock, compared against the oldest prediction.
    initial begin
        obs_t  e, a;
        string t;
        forever begin
            @(posedge msoc_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {rst_out_n, done, halt, wdt_fired, restart_cnt, seq_state};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s vec=%0d got rst=%b done=%b halt=%b wdt=%b rc=%0d st=%0d exp rst=%b done=%b halt=%b wdt=%b rc=%0d st=%0d",
                             t, vectors, a.rst, a.done, a.halt, a.fired, a.rc, a.st,
                             e.rst, e.done, e.halt, e.fired, e.rc, e.st);
                end else begin
                    $display("vec %0d %s rst_out_n=%b done=%b halt=%b rc=%0d st=%0d",
                             vectors, t, a.rst, a.done, a.halt, a.rc, a.st);
                end
            end
        end
    end

    initial begin
        repeat (3) step(0, 0, 0, 0, '0, "reset");
        repeat (25) step(1, 0, 0, 0, '0, "sequence");

        // High 2, low 1, high 3: only the last high completes the filter.
        step(1, 1, 0, 0, '0, "brk_filter"); step(1, 1, 0, 0, '0, "brk_filter");
        step(1, 0, 0, 0, '0, "brk_filter");
        repeat (3) step(1, 1, 0, 0, '0, "brk_filter");
        repeat (25) step(1, 0, 0, 0, '0, "resequence");

        for (int j = 0; j < 10 && m_phase != 2; j++) begin
            wait_run();
            repeat (BRK_FILT) step(1, 1, 0, 0, '0, "brk_to_halt");
            step(1, 0, 0, 0, '0, "brk_to_halt");
        end
        repeat (5) step(1, 1, 0, 0, '0, "halt_hold");
        step(1, 0, 1, 0, '0, "halt_sw");
        repeat (25) step(1, 0, 0, 0, '0, "halt_replay");

        wait_run();
        repeat (BRK_FILT - 1) step(1, 1, 0, 0, '0, "sw_vs_brk");
        step(1, 1, 1, 0, '0, "sw_vs_brk");
        repeat (5) step(1, 0, 0, 0, '0, "sw_vs_brk");

        step(0, 0, 0, 0, '0, "rst_mid");
        repeat (13) step(1, 0, 0, 0, '0, "rst_mid");
        step(0, 0, 0, 0, '0, "rst_mid_low");
        repeat (25) step(1, 0, 0, 0, '0, "rst_mid");

        wait_run();
        repeat (120) step(1, 0, 0, 0, 16'd100, "wdt_nokick");
        wait_run();
        for (int i = 1; i <= 220; i++) step(1, 0, 0, (i % 50) == 0, 16'd100, "wdt_kick");

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 3) == 0) ? '0 : WDT_W'($urandom_range(5, 40)),
                 "random");
        end
        step(1, 0, 0, 0, '0, "drain");

        @(posedge msoc_clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending predictions exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
